// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the BTB branch predictor: index-width helper,
// direction-counter constants and PC field bit offsets.
package branch_predictor_pkg;

  // PC bit where the BTB index starts (instructions are word aligned)
  localparam int PC_IDX_LSB = 2;

  // Number of index bits needed to address a table of the given size
  function automatic int bpu_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Saturation ceiling of a CTR_W-bit direction counter
  function automatic int ctr_max(input int ctr_w);
    return (1 << ctr_w) - 1;
  endfunction

  // Weakly-taken value used when a new entry is allocated
  function automatic int ctr_weak_t(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // Bit offset of the tag field inside the PC for a given index width
  function automatic int pc_tag_lsb(input int idx_w);
    return PC_IDX_LSB + idx_w;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// Saturating up/down direction counter; purely combinational next value.
module bpu_sat_ctr
  import branch_predictor_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max(CTR_W));

  // Step towards taken on inc, towards not-taken otherwise, clamping at the ends
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_W'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating-counter direction prediction.
// IF lookup is combinational from table state; EX resolution raises a
// same-cycle mispredict/redirect; the table trains once per resolved
// instruction (never while stalled).
// Optional: define BPU_PERF_CNT_EN to add perf_branches/perf_mispredicts.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int IDX_W   = bpu_idx_w(ENTRIES);
  localparam int TAG_LSB = pc_tag_lsb(IDX_W);
  localparam int TGT_W   = XLEN - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(ctr_weak_t(CTR_W));

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [TGT_W-1:0] target_q [ENTRIES];
  logic [TGT_W-1:0] target_d [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];
  logic [CTR_W-1:0] ctr_d    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             upd;
  logic [CTR_W-1:0] ctr_step;

  assign if_idx = if_pc[PC_IDX_LSB +: IDX_W];
  assign if_tag = if_pc[TAG_LSB +: TAG_W];
  assign ex_idx = ex_pc[PC_IDX_LSB +: IDX_W];
  assign ex_tag = ex_pc[TAG_LSB +: TAG_W];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Lookup reads pre-update state: no bypass from a same-cycle update
  assign pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
  assign pred_target = pred_taken ? {target_q[if_idx], 2'b00} : if_pc + XLEN'(4);

  // Resolve the EX instruction against what was predicted for it in IF
  always_comb begin
    mispredict = 1'b0;
    if (ex_valid) begin
      if (ex_is_branch)
        mispredict = (ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target != ex_pred_target));
      else
        mispredict = ex_pred_taken;  // aliased entry predicted a non-branch taken
    end
  end

  assign redirect_pc = (ex_valid && ex_is_branch && ex_taken) ? ex_target
                                                              : ex_pc + XLEN'(4);

  // A stalled EX holds the same instruction, so it must train only once
  assign upd = ex_valid && !stall;

  bpu_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr_i (ctr_q[ex_idx]),
    .inc_i (ex_taken),
    .ctr_o (ctr_step)
  );

  // Next table state: train on hit, allocate on taken miss, drop aliased entries
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          ctr_d[ex_idx] = ctr_step;
          if (ex_taken) target_d[ex_idx] = ex_target[XLEN-1:2];
        end else if (ex_taken) begin
          valid_d[ex_idx]  = 1'b1;
          tag_d[ex_idx]    = ex_tag;
          target_d[ex_idx] = ex_target[XLEN-1:2];
          ctr_d[ex_idx]    = CTR_WEAK_T;
        end
      end else if (ex_hit) begin
        valid_d[ex_idx] = 1'b0;
      end
    end
  end

  // Table registers; tag/target are cleared only to keep simulation X-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '{default: 1'b0};
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: '0};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  // Event counters advance once per resolved instruction and wrap naturally
  always_comb begin
    perf_branches_d    = perf_branches_q + ((upd && ex_is_branch) ? 32'd1 : 32'd0);
    perf_mispredicts_d = perf_mispredicts_q + ((upd && mispredict) ? 32'd1 : 32'd0);
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all checked against a table-level reference model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;
  localparam int TAG_W   = 8;
  localparam int CTR_W   = 2;
  localparam int CTR_TOP = (1 << CTR_W) - 1;
  localparam int CTR_WK  = 1 << (CTR_W - 1);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] if_pc = 32'h0040_0000;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        ex_is_branch = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = 32'h0;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // reference model state, kept as plain numbers per index
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_br    = 0;
  int unsigned m_misp  = 0;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
`ifdef BPU_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= CTR_WK);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    if (!ex_valid) return 1'b0;
    if (ex_is_branch) return (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
    return ex_pred_taken;
  endfunction

  function automatic logic [31:0] m_redirect();
    return (ex_valid && ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
    end
    m_br   = 0;
    m_misp = 0;
  endtask

  task automatic m_update();
    int unsigned i;
    if (!(ex_valid && !stall)) return;
    i = m_idx(ex_pc);
    if (ex_is_branch) m_br++;
    if (m_mispredict()) m_misp++;
    if (ex_is_branch) begin
      if (m_hit(ex_pc)) begin
        if (ex_taken) begin
          m_ctr[i] = (m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP;
          m_tgt[i] = ex_target & 32'hFFFF_FFFC;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ex_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(ex_pc);
        m_tgt[i]   = ex_target & 32'hFFFF_FFFC;
        m_ctr[i]   = CTR_WK;
      end
    end else if (m_hit(ex_pc)) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // One transaction: compare outputs mid-cycle, then let the edge train both sides
  task automatic cycle();
    @(negedge clk);
    check("pred_taken",  pred_taken,  m_pred_taken(if_pc));
    check("pred_target", pred_target, m_pred_target(if_pc));
    check("mispredict",  mispredict,  m_mispredict());
    check("redirect_pc", redirect_pc, m_redirect());
`ifdef BPU_PERF_CNT_EN
    check("perf_branches",    perf_branches,    m_br);
    check("perf_mispredicts", perf_mispredicts, m_misp);
`endif
    $display("txn %0d rst_n=%b stall=%b if_pc=%h pt=%b ptgt=%h ex_v=%b ex_pc=%h br=%b tk=%b misp=%b redir=%h",
             n_txn, reset, stall, if_pc, pred_taken, pred_target, ex_valid, ex_pc,
             ex_is_branch, ex_taken, mispredict, redirect_pc);
    n_txn++;
    @(posedge clk);
    if (reset) m_update();
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_pc          = pc;
    ex_is_branch   = br;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 9))
      0:       return 32'h0040_0000 + 32'h100 * $urandom_range(1, 3) + 4 * $urandom_range(0, 15);
      1:       return 32'hFFFF_FFFC;
      default: return 32'h0040_0000 + 4 * $urandom_range(0, 15);
    endcase
  endfunction

  initial begin
    m_clear();
    // asynchronous reset, checked while still asserted
    #2 reset = 1'b0;
    m_clear();
    @(posedge clk);
    #1;
    check("rst_pred_taken",  pred_taken,  1'b0);
    check("rst_pred_target", pred_target, 32'h0040_0004);
    cycle();
    reset = 1'b1;

    // taken beq at 0x00400010 predicted not-taken: allocate + redirect
    drive_ex(1, 32'h0040_0010, 1, 1, 32'h0040_0040, 0, 32'h0040_0014);
    #1;
    check("alloc_misp",  mispredict,  1'b1);
    check("alloc_redir", redirect_pc, 32'h0040_0040);
    cycle();
    drive_ex(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    if_pc = 32'h0040_0010;
    #1;
    check("hit_taken",  pred_taken,  1'b1);
    check("hit_target", pred_target, 32'h0040_0040);
    cycle();

    // three more taken (saturate at 3), then two not-taken (3->2->1)
    repeat (3) begin
      drive_ex(1, 32'h0040_0010, 1, 1, 32'h0040_0040, 1, 32'h0040_0040);
      cycle();
    end
    drive_ex(1, 32'h0040_0010, 1, 0, 32'h0040_0040, 1, 32'h0040_0040);
    cycle();
    // same-index lookup during the update still sees the old (taken) counter
    #1;
    check("same_idx_old", pred_taken,  1'b1);
    check("nt_redir",     redirect_pc, 32'h0040_0014);
    cycle();
    drive_ex(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    check("after_nt", pred_taken, 1'b0);
    cycle();

    // stall: counter 2 -> held 5 cycles -> 1 exactly once -> train taken -> 2
    drive_ex(1, 32'h0040_0010, 1, 1, 32'h0040_0040, 0, 32'h0040_0014);
    cycle();
    drive_ex(1, 32'h0040_0010, 1, 0, 32'h0040_0040, 1, 32'h0040_0040);
    stall = 1'b1;
    repeat (5) begin
      #1;
      check("stall_misp", mispredict, 1'b1);
      cycle();
    end
    stall = 1'b0;
    cycle();
    drive_ex(1, 32'h0040_0010, 1, 1, 32'h0040_0040, 0, 32'h0040_0014);
    cycle();
    drive_ex(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    check("stall_once", pred_taken, 1'b1);
    cycle();

    // aliasing: non-branch at a trained PC predicted taken
    drive_ex(1, 32'h0040_0010, 0, 0, 32'h0, 1, 32'h0040_0040);
    #1;
    check("alias_misp",  mispredict,  1'b1);
    check("alias_redir", redirect_pc, 32'h0040_0014);
    cycle();
    drive_ex(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    check("alias_inval", pred_taken, 1'b0);
    cycle();

    // mid-run reset during an update clears the trained entry
    drive_ex(1, 32'h0040_0020, 1, 1, 32'h0040_0100, 0, 32'h0040_0024);
    if_pc = 32'h0040_0020;
    cycle();
    drive_ex(1, 32'h0040_0020, 1, 1, 32'h0040_0100, 1, 32'h0040_0100);
    #1;
    check("pre_rst_taken", pred_taken, 1'b1);
    reset = 1'b0;
    m_clear();
    #1;
    check("rst_mid_pred", pred_taken, 1'b0);
    check("rst_mid_misp", mispredict, 1'b0);
    cycle();
    reset = 1'b1;
    drive_ex(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    check("rst_release", pred_taken, 1'b0);
    cycle();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc_e;
      logic [31:0] tgt;
      pc_e = rand_pc();
      tgt  = rand_pc();
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if_pc = ($urandom_range(0, 3) == 0) ? pc_e : rand_pc();
      if ($urandom_range(0, 1) == 0)
        drive_ex($urandom_range(0, 6) != 0, pc_e, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 tgt, m_pred_taken(pc_e), m_pred_target(pc_e));
      else
        drive_ex($urandom_range(0, 6) != 0, pc_e, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 tgt, 1'($urandom_range(0, 1)), rand_pc());
      stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        m_clear();
        cycle();
        reset = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with saturating-counter direction prediction for the 5-stage PCPU pipeline.
- Predicts taken/target for the IF-stage PC in the same cycle as the lookup.
- Trains on branches resolved in EX and raises a same-cycle mispredict/redirect so the top level can flush IF/ID and ID/EX.
- Replaces fixed "predict not-taken, resolve in EX" branch handling.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, 4..1024; IDX_W = log2(ENTRIES).
- TAG_W, 8, PC tag bits stored per entry; IDX_W+TAG_W+2 <= 32.
- CTR_W, 2, saturating direction-counter width; 1..4.
- XLEN, 32, PC/target width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline frozen (MIO_ready low or load-use); blocks table updates.
- if_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  IF prediction: taken.
- pred_target  out  XLEN  IF predicted target; equals if_pc+4 when not taken.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_is_branch  in  1  EX instruction is beq/bne/j.
- ex_taken  in  1  resolved direction (j is always 1).
- ex_target  in  XLEN  resolved taken target.
- ex_pred_taken  in  1  pred_taken carried down the pipe with the instruction.
- ex_pred_target  in  XLEN  pred_target carried down the pipe.
- mispredict  out  1  flush IF/ID and ID/EX; select redirect_pc into PC.
- redirect_pc  out  XLEN  correct next PC.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[XLEN-2] (word-aligned), ctr[CTR_W]. idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Lookup is combinational from registered state. hit = valid && tag match. pred_taken = hit && ctr[CTR_W-1]. pred_target = pred_taken ? {target,2'b00} : if_pc+4 (modulo 2^XLEN).
- Resolution is combinational, gated by ex_valid.
  - Branch: mispredict = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target).
  - Non-branch with ex_pred_taken=1 (aliased entry): mispredict = 1.
  - redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc+4.
  - With ex_valid=0, mispredict = 0 and redirect_pc = ex_pc+4.
- Update happens on the posedge when upd = ex_valid && !stall. It happens exactly once per resolved instruction, because a stalled EX holds the same instruction and must not train repeatedly.
  - Branch, hit, taken: ctr saturating +1 (max 2^CTR_W-1); target <= ex_target.
  - Branch, hit, not taken: ctr saturating -1 (min 0).
  - Branch, miss, taken: allocate (valid=1, tag, target). ctr = 2^(CTR_W-1), i.e. weakly taken. Overwrites any occupant.
  - Branch, miss, not taken: no change.
  - Non-branch, hit: valid <= 0.
- Simultaneous lookup and update to the same index: lookup returns the pre-update state; no bypass.
- Reset (asynchronous, any time, including mid-update): all valid <= 0, all ctr <= 0. tag/target are don't-care but are cleared to 0 for X-free simulation.
  - While reset is asserted: pred_taken=0, pred_target=if_pc+4, mispredict follows the ex_* inputs.
  - First update occurs on the first posedge after reset deasserts.
- CTR_W=1: counter is a last-outcome bit; allocation value is 1.

Optional Feature:
- BPU_PERF_CNT_EN
- Defined: adds outputs perf_branches[31:0] and perf_mispredicts[31:0].
  - perf_branches increments on upd && ex_is_branch.
  - perf_mispredicts increments on upd && mispredict.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define file (alongside ctrl_encode_def.v): BPU_IDX_W macro function, counter constants CTR_MAX/CTR_WEAK_T, entry-field bit offsets.
- One sub-module: bpu_sat_ctr (parametrised CTR_W saturating inc/dec, combinational next-value). The table array, lookup, resolution and update stay in branch_predictor.

Test Plan:
- Reset, then if_pc=0x00400000 -> pred_taken=0, pred_target=0x00400004. Hold reset low mid-run after training -> all entries invalid on release.
- Taken beq at ex_pc=0x00400010, ex_target=0x00400040, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x00400040. Next cycle if_pc=0x00400010 -> pred_taken=1, pred_target=0x00400040.
- Train the same branch taken 3 more times (ctr=3), then resolve not-taken twice -> ctr 2 then 1. Next lookup pred_taken=0; the not-taken mispredict gives redirect_pc=0x00400014.
- Trained entry, stall=1 for 5 cycles with the same ex_* held -> ctr changes exactly once (after stall drops); mispredict is asserted throughout.
- Aliasing: ENTRIES=64, PC 0x00400010 trained taken, then non-branch at 0x00400010 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x00400014, entry invalidated.
- Same-cycle lookup/update on index 4 -> lookup shows old ctr. With BPU_PERF_CNT_EN, after the sequence above perf_branches and perf_mispredicts match the scoreboard counts.
